discus_loader: RTL and testbench
================================

# discus_loader

Hardware load/debug controller for a discus CPU. It takes a byte-stream command protocol from a UART receiver and sequences the CPU's program RAM and data RAM write/read ports and the CPU reset line. Every command returns exactly one response byte on the transmit stream. It sits between the serial front end and the discus memories, so the CPU can be loaded and inspected without a second monitor processor.

## Interface
Parameters:
- AW, 8, address width of program and data RAM; addresses wrap modulo 2^AW.
- RSP_BAD, 8'hFF, response byte for an unknown opcode.
- RSP_BUSY, 8'hFE, response byte for a program write refused while the CPU is running.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  command/argument byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  controller accepts the byte; transfer happens on an edge with valid&ready.
- tx_data  out  8  response byte.
- tx_valid  out  1  response byte is valid.
- tx_ready  in  1  sink accepts the byte; transfer happens on an edge with valid&ready.
- prog_addr  out  AW  program RAM address; always equals the internal paddr register.
- prog_wdata  out  8  program RAM write data.
- prog_we  out  1  program RAM write strobe, one cycle wide.
- prog_rdata  in  8  program RAM read data, registered, valid 1 cycle after prog_addr.
- mem_addr, mem_wdata, mem_we, mem_rdata  same as prog_* but for data RAM and the daddr register.
- cpu_reset  out  1  active-high reset to the discus CPU.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
Opcodes. Any other opcode responds RSP_BAD and its state is unchanged.
- 0x01 A: paddr<=A; respond 0x01.
- 0x02 D: if cpu_reset=1, write prog[paddr]<=D, paddr++, respond 0x02. If cpu_reset=0, do not write, leave paddr unchanged, respond RSP_BUSY.
- 0x03: respond prog[paddr]; paddr++.
- 0x04 A: daddr<=A; respond 0x04.
- 0x05 D: write mem[daddr]<=D, daddr++, respond 0x05. Always allowed; the CPU and the loader share the RAM write-first.
- 0x06: respond mem[daddr]; daddr++.
- 0x07 V: cpu_reset<=V[0]; respond 0x07.
- 0x08: respond {7'b0, cpu_reset}.

FSM states:
- IDLE: rx_ready=1. Opcode accepted → ARG (0x01/02/04/05/07), RDWAIT (0x03/06), or RESP (0x08/unknown).
- ARG: rx_ready=1. Argument accepted → EXEC.
- EXEC: one cycle. Performs the write strobe or register update → RESP.
- RDWAIT: one cycle while the RAM read completes. Latches rdata into tx_data and increments the address → RESP.
- RESP: tx_valid=1 with tx_data held stable. Handshake → IDLE.

Rules:
- rx_ready=0 in EXEC, RDWAIT and RESP, so at most one command is in flight.
- Address increment wraps (2^AW−1)+1 → 0.

## Timing
- Reset values: cpu_reset=1; paddr=daddr=0; tx_valid=0; tx_data=0; prog_we=mem_we=0; rx_ready=0 while reset_n=0; busy=0; state=IDLE.
- The first cycle after reset_n rises has rx_ready=1.
- Write command with argument accepted on edge M: EXEC cycle M+1 has we=1 and addr=old value. Address increments on edge M+1. tx_valid=1 from cycle M+2.
- Read command with opcode accepted on edge N: RDWAIT in cycle N+1. tx_valid=1 in cycle N+2 with tx_data=RAM[address at N]. Address is incremented at edge N+1 (prog_addr changes after the read has been sampled).
- tx_ready held low: tx_valid and tx_data stay constant indefinitely, and no rx byte is accepted.
- Minimum throughput is one command per 3 cycles (no-argument commands) or 4 cycles (argument commands) with rx_valid and tx_ready tied high.
- Asserting reset_n mid-command (e.g. in ARG or RESP): all outputs return to reset values immediately. The partially received command and any pending response are discarded, and cpu_reset reasserts.

## Test plan
- Reset check, then 0x01 0x10, 0x02 0xAB, 0x02 0xCD, 0x01 0x10, 0x03, 0x03. Required: responses 01,02,02,01,AB,CD; prog_we pulses with addr 0x10 then 0x11; final paddr=0x12.
- 0x04 0xFF, 0x05 0x5A, 0x06 → responses 04,05, then the read returns mem[0x00] (wrapped); daddr=0x01. A further 0x04 0xFF, 0x06 → 5A.
- 0x07 0x00 then 0x02 0x77 → responses 07, FE; no prog_we pulse; paddr unchanged. Then 0x07 0x01, 0x08 → 07, 01.
- Opcode 0x3C → response FF; next byte 0x08 is treated as an opcode (response 01).
- tx_ready held low 20 cycles during RESP → tx_valid/tx_data stable, rx_ready=0 throughout, response delivered once when released.
- reset_n pulsed low in ARG after 0x07 with cpu_reset previously 0 → cpu_reset=1 asynchronously, no response emitted, next opcode 0x08 returns 01.

Source files
------------

// File: rtl/discus_loader_if.sv
// Byte-stream channel between the UART front end and the discus loader.
// The host side uses the master modport and the loader uses the slave modport.
interface discus_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/discus_loader.sv
// Load/debug controller for the discus CPU. It decodes one byte command at a
// time and drives the program/data RAM ports and the CPU reset line.
module discus_loader #(
  parameter int         AW       = 8,
  parameter logic [7:0] RSP_BAD  = 8'hFF,
  parameter logic [7:0] RSP_BUSY = 8'hFE
) (
  input  logic          clk,
  input  logic          reset_n,
  discus_loader_if.slave bus,
  output logic [AW-1:0] prog_addr,
  output logic [7:0]    prog_wdata,
  output logic          prog_we,
  input  logic [7:0]    prog_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic [7:0]    mem_rdata,
  output logic          cpu_reset,
  output logic          busy
);

  localparam logic [7:0] OP_SET_PADDR = 8'h01;
  localparam logic [7:0] OP_PROG_WR   = 8'h02;
  localparam logic [7:0] OP_PROG_RD   = 8'h03;
  localparam logic [7:0] OP_SET_DADDR = 8'h04;
  localparam logic [7:0] OP_MEM_WR    = 8'h05;
  localparam logic [7:0] OP_MEM_RD    = 8'h06;
  localparam logic [7:0] OP_SET_RST   = 8'h07;
  localparam logic [7:0] OP_GET_RST   = 8'h08;

  typedef enum logic [2:0] {
    IDLE,
    ARG,
    EXEC,
    RDWAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    opcode;
  logic [7:0]    arg;
  logic [7:0]    tx_data_q;
  logic [AW-1:0] paddr;
  logic [AW-1:0] daddr;
  logic          rx_ready;
  logic          tx_valid;
  logic          rx_fire;
  logic          tx_fire;

  function automatic logic needs_arg(input logic [7:0] op);
    return op inside {OP_SET_PADDR, OP_PROG_WR, OP_SET_DADDR, OP_MEM_WR, OP_SET_RST};
  endfunction

  function automatic logic is_read(input logic [7:0] op);
    return op inside {OP_PROG_RD, OP_MEM_RD};
  endfunction

  assign rx_fire = bus.rx_valid & rx_ready;
  assign tx_fire = tx_valid & bus.tx_ready;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this block free of inferred
  // latches on paths the case statement does not mention.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rx_fire) begin
          if (needs_arg(bus.rx_data)) begin
            state_nxt = ARG;
          end else if (is_read(bus.rx_data)) begin
            state_nxt = RDWAIT;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      ARG: begin
        if (rx_fire) begin
          state_nxt = EXEC;
        end
      end
      EXEC:   state_nxt = RESP;
      RDWAIT: state_nxt = RESP;
      RESP: begin
        if (tx_fire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode. rx_ready is also gated by reset_n so it drops the moment
  // reset is applied rather than waiting for the state register.
  always_comb begin
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    prog_we  = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE: begin
        rx_ready = reset_n;
        busy     = 1'b0;
      end
      ARG:    rx_ready = reset_n;
      EXEC: begin
        prog_we = (opcode == OP_PROG_WR) && cpu_reset;
        mem_we  = (opcode == OP_MEM_WR);
      end
      RDWAIT: ;
      RESP:   tx_valid = 1'b1;
      default: ;
    endcase
  end

  // Command datapath: opcode/argument capture, address registers, CPU reset
  // and the response byte, which only changes outside RESP so it stays stable
  // while the sink stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opcode    <= '0;
      arg       <= '0;
      paddr     <= '0;
      daddr     <= '0;
      cpu_reset <= 1'b1;
      tx_data_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_fire) begin
            opcode <= bus.rx_data;
            if (bus.rx_data == OP_GET_RST) begin
              tx_data_q <= {7'b0, cpu_reset};
            end else if (!needs_arg(bus.rx_data) && !is_read(bus.rx_data)) begin
              tx_data_q <= RSP_BAD;
            end
          end
        end
        ARG: begin
          if (rx_fire) begin
            arg <= bus.rx_data;
          end
        end
        EXEC: begin
          unique case (opcode)
            OP_SET_PADDR: begin
              paddr     <= AW'(arg);
              tx_data_q <= OP_SET_PADDR;
            end
            OP_PROG_WR: begin
              // A running CPU owns program RAM; refuse without touching paddr.
              if (cpu_reset) begin
                paddr     <= paddr + AW'(1);
                tx_data_q <= OP_PROG_WR;
              end else begin
                tx_data_q <= RSP_BUSY;
              end
            end
            OP_SET_DADDR: begin
              daddr     <= AW'(arg);
              tx_data_q <= OP_SET_DADDR;
            end
            OP_MEM_WR: begin
              daddr     <= daddr + AW'(1);
              tx_data_q <= OP_MEM_WR;
            end
            OP_SET_RST: begin
              cpu_reset <= arg[0];
              tx_data_q <= OP_SET_RST;
            end
            default: tx_data_q <= RSP_BAD;
          endcase
        end
        RDWAIT: begin
          // The RAM sampled the address during the opcode cycle, so rdata is
          // valid now and the address may advance on this edge.
          if (opcode == OP_PROG_RD) begin
            tx_data_q <= prog_rdata;
            paddr     <= paddr + AW'(1);
          end else begin
            tx_data_q <= mem_rdata;
            daddr     <= daddr + AW'(1);
          end
        end
        RESP: ;
        default: ;
      endcase
    end
  end

  assign bus.rx_ready = rx_ready;
  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_data_q;
  assign prog_addr    = paddr;
  assign prog_wdata   = arg;
  assign mem_addr     = daddr;
  assign mem_wdata    = arg;

endmodule

// File: tb/tb_discus_loader.sv
// Self-checking bench for discus_loader: drives command bytes, models both
// RAMs, and compares response bytes popped from an expected-response queue.
module tb_discus_loader;
  localparam int AW = 8;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_wdata;
  logic          prog_we;
  logic [7:0]    prog_rdata;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [7:0]    mem_rdata;
  logic          cpu_reset;
  logic          busy;

  discus_loader_if bus ();

  discus_loader #(.AW(AW), .RSP_BAD(8'hFF), .RSP_BUSY(8'hFE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .prog_we    (prog_we),
    .prog_rdata (prog_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]    exp_q[$];
  logic [AW-1:0] we_addr_q[$];
  logic [7:0]    we_data_q[$];

  logic [7:0] prog_ram [256];
  logic [7:0] mem_ram  [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) begin
      prog_ram[i] = 8'h00;
      mem_ram[i]  = 8'(i) ^ 8'h3C;
    end
  end

  // Registered-read RAM models, write-first.
  always @(posedge clk) begin
    if (prog_we) begin
      prog_ram[prog_addr] <= prog_wdata;
      prog_rdata          <= prog_wdata;
    end else begin
      prog_rdata <= prog_ram[prog_addr];
    end
    if (mem_we) begin
      mem_ram[mem_addr] <= mem_wdata;
      mem_rdata         <= mem_wdata;
    end else begin
      mem_rdata <= mem_ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (prog_we === 1'b1) begin
      we_addr_q.push_back(prog_addr);
      we_data_q.push_back(prog_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.rx_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic recv_resp(input string name);
    int n = 0;
    logic [7:0] expv;
    @(negedge clk);
    while (bus.tx_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    total++;
    if (bus.tx_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s: no response within 50 cycles, expected %h", name, expv);
    end else begin
      if (bus.tx_data !== expv) begin
        bad++;
        $display("FAIL %s: response %h expected %h", name, bus.tx_data, expv);
      end
      bus.tx_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_ready = 1'b0;
    end
  endtask

  task automatic do_cmd(input string name, input logic [7:0] op, input bit has_arg,
                        input logic [7:0] a, input logic [7:0] expv);
    exp_q.push_back(expv);
    send_byte(op);
    if (has_arg) send_byte(a);
    recv_resp(name);
  endtask

  task automatic test_reset;
    reset_n      = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (cpu_reset !== 1'b1 || bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b0 ||
        busy !== 1'b0 || prog_we !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: cpu_reset=%b tx_valid=%b rx_ready=%b busy=%b we=%b%b expected 1 0 0 0 00",
               cpu_reset, bus.tx_valid, bus.rx_ready, busy, prog_we, mem_we);
    end
    total++;
    if (prog_addr !== 8'h00 || mem_addr !== 8'h00 || bus.tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: paddr=%h daddr=%h tx_data=%h expected 00 00 00",
               prog_addr, mem_addr, bus.tx_data);
    end
    reset_n = 1'b1;
    #1;
    total++;
    if (bus.rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: rx_ready=%b expected 1", bus.rx_ready);
    end
  endtask

  task automatic test_prog;
    we_addr_q.delete();
    we_data_q.delete();
    do_cmd("set_paddr", 8'h01, 1, 8'h10, 8'h01);

    exp_q.push_back(8'h02);
    send_byte(8'h02);
    send_byte(8'hAB);
    @(negedge clk);
    total++;
    if (prog_we !== 1'b1 || prog_addr !== 8'h10 || prog_wdata !== 8'hAB) begin
      bad++;
      $display("FAIL exec_write: we=%b addr=%h wdata=%h expected 1 10 ab", prog_we, prog_addr, prog_wdata);
    end
    @(negedge clk);
    total++;
    if (prog_we !== 1'b0 || bus.tx_valid !== 1'b1 || prog_addr !== 8'h11) begin
      bad++;
      $display("FAIL write_resp_cycle: we=%b tx_valid=%b addr=%h expected 0 1 11",
               prog_we, bus.tx_valid, prog_addr);
    end
    recv_resp("prog_wr_ab");

    do_cmd("prog_wr_cd", 8'h02, 1, 8'hCD, 8'h02);
    do_cmd("set_paddr2", 8'h01, 1, 8'h10, 8'h01);

    exp_q.push_back(8'hAB);
    send_byte(8'h03);
    @(negedge clk);
    total++;
    if (bus.tx_valid !== 1'b0 || busy !== 1'b1 || prog_addr !== 8'h10) begin
      bad++;
      $display("FAIL rdwait_cycle: tx_valid=%b busy=%b addr=%h expected 0 1 10",
               bus.tx_valid, busy, prog_addr);
    end
    recv_resp("prog_rd_ab");
    do_cmd("prog_rd_cd", 8'h03, 0, 8'h00, 8'hCD);

    total++;
    if (we_addr_q.size() != 2 || we_addr_q[0] !== 8'h10 || we_addr_q[1] !== 8'h11 ||
        we_data_q[0] !== 8'hAB || we_data_q[1] !== 8'hCD) begin
      bad++;
      $display("FAIL prog_we_log: %0d strobes seen, expected 2 at 10/ab and 11/cd", we_addr_q.size());
    end
    total++;
    if (prog_addr !== 8'h12) begin
      bad++;
      $display("FAIL final_paddr: got %h expected 12", prog_addr);
    end
  endtask

  task automatic test_mem;
    do_cmd("set_daddr_ff", 8'h04, 1, 8'hFF, 8'h04);
    do_cmd("mem_wr_5a", 8'h05, 1, 8'h5A, 8'h05);
    total++;
    if (mem_addr !== 8'h00) begin
      bad++;
      $display("FAIL daddr_wrap: got %h expected 00", mem_addr);
    end
    do_cmd("mem_rd_wrapped", 8'h06, 0, 8'h00, 8'h3C);
    total++;
    if (mem_addr !== 8'h01) begin
      bad++;
      $display("FAIL daddr_after_rd: got %h expected 01", mem_addr);
    end
    do_cmd("set_daddr_ff2", 8'h04, 1, 8'hFF, 8'h04);
    do_cmd("mem_rd_5a", 8'h06, 0, 8'h00, 8'h5A);
  endtask

  task automatic test_cpu_running;
    we_addr_q.delete();
    do_cmd("run_cpu", 8'h07, 1, 8'h00, 8'h07);
    do_cmd("prog_wr_busy", 8'h02, 1, 8'h77, 8'hFE);
    total++;
    if (we_addr_q.size() != 0 || prog_addr !== 8'h12) begin
      bad++;
      $display("FAIL busy_no_write: strobes=%0d paddr=%h expected 0 12", we_addr_q.size(), prog_addr);
    end
    do_cmd("halt_cpu", 8'h07, 1, 8'h01, 8'h07);
    do_cmd("get_rst", 8'h08, 0, 8'h00, 8'h01);
  endtask

  task automatic test_bad_opcode;
    do_cmd("bad_opcode", 8'h3C, 0, 8'h00, 8'hFF);
    do_cmd("after_bad", 8'h08, 0, 8'h00, 8'h01);
  endtask

  task automatic test_tx_stall;
    int errs = 0;
    bus.tx_ready = 1'b0;
    exp_q.push_back(8'h01);
    send_byte(8'h08);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h01 || bus.rx_ready !== 1'b0) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL stall_hold: %0d unstable cycles, expected 0", errs);
    end
    recv_resp("stall_release");
    @(negedge clk);
    total++;
    if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_once: tx_valid=%b rx_ready=%b expected 0 1", bus.tx_valid, bus.rx_ready);
    end
  endtask

  task automatic test_reset_mid_cmd;
    int errs = 0;
    do_cmd("run_cpu2", 8'h07, 1, 8'h00, 8'h07);
    total++;
    if (cpu_reset !== 1'b0) begin
      bad++;
      $display("FAIL cpu_running: cpu_reset=%b expected 0", cpu_reset);
    end
    send_byte(8'h07);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if (cpu_reset !== 1'b1 || bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: cpu_reset=%b tx_valid=%b rx_ready=%b busy=%b expected 1 0 0 0",
               cpu_reset, bus.tx_valid, bus.rx_ready, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL no_stale_resp: tx_valid high %0d cycles, expected 0", errs);
    end
    do_cmd("get_rst_after_reset", 8'h08, 0, 8'h00, 8'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_prog();
    test_mem();
    test_cpu_running();
    test_bad_opcode();
    test_tx_stall();
    test_reset_mid_cmd();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
